// File: rtl/subtract_top.sv
// rtl/subtract_top.sv - ped/mask pixel highlighter with FIFOs; optional border marking under HIGHLIGHT_BORDER_EN

// Synchronous FIFO with first-word-fall-through read side; DEPTH must be a power of two
module subtract_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  output logic          full,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = rd_en && !empty;
  // A push into a full FIFO is still taken when the head leaves in the same cycle
  assign do_push = wr_en && (!full || do_pop);
  // Head is forced to zero while empty so the read port is clean out of reset
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while the pointers say empty
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// Top level: two input FIFOs, one registered combine stage, one output FIFO
module subtract_top #(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 576,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_wr_en_ped,
  input  logic [23:0] in_din_ped,
  output logic        in_full_ped,
  input  logic        in_wr_en_mask,
  input  logic [23:0] in_din_mask,
  output logic        in_full_mask,
  input  logic        out_rd_en,
  output logic [23:0] out_dout,
  output logic        out_empty
);
  logic [23:0] ped_head;
  logic [23:0] mask_head;
  logic        ped_empty;
  logic        mask_empty;
  logic        out_full;
  logic        fire;
  logic        stage_valid;
  logic [23:0] stage_data;
  logic        stage_push;
  logic [23:0] push_data;
  logic [23:0] combined;

  // Geometry sanity: an empty marker block that only elaborates for nonsensical settings
  if (WIDTH < 2 || HEIGHT < 2 || FIFO_DEPTH < 4) begin : g_bad_geometry
  end

  subtract_fifo #(.DW(24), .DEPTH(FIFO_DEPTH)) u_ped_fifo (
    .clock(clock), .reset(reset),
    .wr_en(in_wr_en_ped), .din(in_din_ped), .full(in_full_ped),
    .rd_en(fire), .dout(ped_head), .empty(ped_empty)
  );

  subtract_fifo #(.DW(24), .DEPTH(FIFO_DEPTH)) u_mask_fifo (
    .clock(clock), .reset(reset),
    .wr_en(in_wr_en_mask), .din(in_din_mask), .full(in_full_mask),
    .rd_en(fire), .dout(mask_head), .empty(mask_empty)
  );

  subtract_fifo #(.DW(24), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clock(clock), .reset(reset),
    .wr_en(stage_push), .din(push_data), .full(out_full),
    .rd_en(out_rd_en), .dout(out_dout), .empty(out_empty)
  );

  // The stage empties whenever the output FIFO has room, counting a same-cycle external pop
  assign stage_push = stage_valid && (!out_full || (out_rd_en && !out_empty));
  // Both heads are consumed together, and only if the stage is free or freeing now
  assign fire       = !ped_empty && !mask_empty && (!stage_valid || stage_push);

  // Pass on a mask hit, otherwise halve each 8-bit channel independently
  always_comb begin
    combined = ped_head;
    if (mask_head == 24'h0) begin
      combined = {1'b0, ped_head[23:17], 1'b0, ped_head[15:9], 1'b0, ped_head[7:1]};
    end
  end

  // Single registered combine stage; holds its pixel until the output FIFO takes it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_valid <= 1'b0;
      stage_data  <= 24'h0;
    end else if (fire) begin
      stage_valid <= 1'b1;
      stage_data  <= combined;
    end else if (stage_push) begin
      stage_valid <= 1'b0;
    end
  end

`ifdef HIGHLIGHT_BORDER_EN
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  // Pixel position of the next output push, kept as column/row to avoid a divider
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          border;

  assign border = (row == '0) || (row == RW'(HEIGHT - 1)) ||
                  (col == '0) || (col == CW'(WIDTH - 1));
  assign push_data = border ? 24'h0000FF : stage_data;

  // Advance on every completed push; frames follow back-to-back
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (stage_push) begin
      if (col == CW'(WIDTH - 1)) begin
        col <= '0;
        row <= (row == RW'(HEIGHT - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
`else
  assign push_data = stage_data;
`endif
endmodule

// File: tb/tb_subtract_top.sv
// tb/tb_subtract_top.sv - randomized and directed bench for subtract_top against a pixel reference model
module tb_subtract_top;
  localparam int W = 16;
  localparam int H = 8;
  localparam int D = 8;
  localparam int TOTAL = W * H;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_wr_en_ped = 1'b0;
  logic [23:0] in_din_ped = 24'h0;
  logic        in_full_ped;
  logic        in_wr_en_mask = 1'b0;
  logic [23:0] in_din_mask = 24'h0;
  logic        in_full_mask;
  logic        out_rd_en = 1'b0;
  logic [23:0] out_dout;
  logic        out_empty;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int pops = 0;
  int n_ped = 0;
  int n_mask = 0;
  logic [23:0] first_out = 24'h0;
  logic [23:0] last_out = 24'h0;
  logic [23:0] ped_q[$];
  logic [23:0] mask_q[$];
  logic [23:0] exp_q[$];

  subtract_top #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset),
    .in_wr_en_ped(in_wr_en_ped), .in_din_ped(in_din_ped), .in_full_ped(in_full_ped),
    .in_wr_en_mask(in_wr_en_mask), .in_din_mask(in_din_mask), .in_full_mask(in_full_mask),
    .out_rd_en(out_rd_en), .out_dout(out_dout), .out_empty(out_empty)
  );

  always #5 clock = ~clock;

  function automatic logic [23:0] ref_pixel(input logic [23:0] p, input logic [23:0] m, input int idx);
`ifdef HIGHLIGHT_BORDER_EN
    int pos;
    int r;
    int c;
    pos = idx % TOTAL;
    r = pos / W;
    c = pos % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 24'h0000FF;
`else
    if (idx < 0) return 24'h0;
`endif
    if (m != 24'h0) return p;
    return {p[23:16] / 8'd2, p[15:8] / 8'd2, p[7:0] / 8'd2};
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: checks the head if popping, then drives the next inputs
  task automatic cycle(input logic wp, input logic [23:0] dp, input logic wm,
                       input logic [23:0] dm, input logic rd);
    logic [23:0] a;
    logic [23:0] b;
    @(negedge clock);
    if (rd && !out_empty) begin
      if (exp_q.size() > 0) check("output_pixel", out_dout, exp_q.pop_front());
      else check("unexpected_output", {23'h0, out_empty}, 24'h1);
      if (pops == 0) first_out = out_dout;
      last_out = out_dout;
      pops++;
    end
    out_rd_en = rd;
    in_wr_en_ped = wp && !in_full_ped;
    in_din_ped = dp;
    in_wr_en_mask = wm && !in_full_mask;
    in_din_mask = dm;
    if (in_wr_en_ped) begin ped_q.push_back(dp); n_ped++; end
    if (in_wr_en_mask) begin mask_q.push_back(dm); n_mask++; end
    while (ped_q.size() > 0 && mask_q.size() > 0) begin
      a = ped_q.pop_front();
      b = mask_q.pop_front();
      exp_q.push_back(ref_pixel(a, b, k));
      k++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    in_wr_en_ped = 1'b0;
    in_wr_en_mask = 1'b0;
    out_rd_en = 1'b0;
    ped_q.delete();
    mask_q.delete();
    exp_q.delete();
    k = 0; pops = 0; n_ped = 0; n_mask = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    // Reset held with writes active
    in_wr_en_ped = 1'b1; in_din_ped = 24'hABCDEF;
    in_wr_en_mask = 1'b1; in_din_mask = 24'h010101;
    out_rd_en = 1'b1;
    repeat (4) @(negedge clock);
    check("reset_full_ped", {23'h0, in_full_ped}, 24'h0);
    check("reset_full_mask", {23'h0, in_full_mask}, 24'h0);
    check("reset_out_empty", {23'h0, out_empty}, 24'h1);
    check("reset_out_dout", out_dout, 24'h0);
    reset = 1'b1;
    in_wr_en_ped = 1'b0; in_wr_en_mask = 1'b0; out_rd_en = 1'b0;
    repeat (5) cycle(1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
    check("post_reset_empty", {23'h0, out_empty}, 24'h1);

    // Pass-through with two-cycle latency
    cycle(1'b1, 24'h123456, 1'b1, 24'hFFFFFF, 1'b0);
    cycle(1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
    cycle(1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
    check("pass_latency_empty", {23'h0, out_empty}, 24'h1);
    cycle(1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
    check("pass_ready", {23'h0, out_empty}, 24'h0);
`ifndef HIGHLIGHT_BORDER_EN
    check("pass_value", out_dout, 24'h123456);
`endif
    repeat (3) cycle(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
    check("pass_count", 24'(pops), 24'd1);

    // Dimming
    cycle(1'b1, 24'hFF8001, 1'b1, 24'h000000, 1'b0);
    repeat (3) cycle(1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
    check("dim_ready", {23'h0, out_empty}, 24'h0);
`ifndef HIGHLIGHT_BORDER_EN
    check("dim_value", out_dout, 24'h7F4000);
`endif
    repeat (3) cycle(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
    check("dim_count", 24'(pops), 24'd2);

    // Imbalance: ped only, then masks
    do_reset();
    repeat (3) cycle(1'b1, 24'($urandom), 1'b0, 24'h0, 1'b1);
    repeat (5) cycle(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
    check("imbalance_empty", {23'h0, out_empty}, 24'h1);
    check("imbalance_nopop", 24'(pops), 24'd0);
    repeat (3) cycle(1'b0, 24'h0, 1'b1, ($urandom_range(0, 1) != 0) ? 24'($urandom) : 24'h0, 1'b0);
    repeat (10) cycle(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
    check("imbalance_count", 24'(pops), 24'd3);

    // Backpressure: fill everything with the output stalled
    do_reset();
    for (int i = 0; i < 80 && !(in_full_ped && in_full_mask); i++)
      cycle(1'b1, 24'($urandom), 1'b1, ($urandom_range(0, 1) != 0) ? 24'($urandom) : 24'h0, 1'b0);
    check("bp_full_ped", {23'h0, in_full_ped}, 24'h1);
    check("bp_full_mask", {23'h0, in_full_mask}, 24'h1);
    check("bp_accepted", 24'(k), 24'(2 * D + 1));
    @(negedge clock);
    in_wr_en_ped = 1'b1; in_din_ped = 24'hDEAD01;
    in_wr_en_mask = 1'b1; in_din_mask = 24'hBEEF02;
    repeat (3) @(negedge clock);
    in_wr_en_ped = 1'b0; in_wr_en_mask = 1'b0;
    check("bp_still_full", {23'h0, in_full_ped}, 24'h1);
    repeat (3 * D + 10) cycle(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
    check("bp_drained", 24'(pops), 24'(2 * D + 1));
    check("bp_empty", {23'h0, out_empty}, 24'h1);

    // Full frame with random traffic and random drain
    do_reset();
    for (int i = 0; i < 20000 && pops < TOTAL; i++)
      cycle((n_ped < TOTAL) && ($urandom_range(0, 3) != 0), 24'($urandom),
            (n_mask < TOTAL) && ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) != 0) ? 24'($urandom) : 24'h0,
            $urandom_range(0, 2) != 0);
    check("frame_count", 24'(pops), 24'(TOTAL));
    check("frame_leftover", 24'(exp_q.size()), 24'd0);
`ifdef HIGHLIGHT_BORDER_EN
    check("frame_first_border", first_out, 24'h0000FF);
    check("frame_last_border", last_out, 24'h0000FF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/subtract_top.md
Name: subtract_top

Overview:
- Pixel-stream highlighter: combines a pedestrian image stream with a binary mask image stream, one 24-bit pixel pair at a time.
- Pixels where the mask is set pass through unchanged; all other pixels are dimmed (per-channel halved).
- Sits between a frame source (two write-side FIFO ports) and a frame sink (one FWFT read-side FIFO port).
- Internally: two input FIFOs, one combine stage and one output FIFO.

Parameters:
- WIDTH, 768, image width in pixels; frame = WIDTH*HEIGHT pixels.
- HEIGHT, 576, image height in pixels.
- FIFO_DEPTH, 16, entries per internal FIFO; power of two, >=4.

Ports:
- clock  in  1  single system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_wr_en_ped  in  1  push in_din_ped into the ped FIFO.
- in_din_ped  in  24  pedestrian pixel; [23:16]=B, [15:8]=G, [7:0]=R (BMP byte order).
- in_full_ped  out  1  ped FIFO full.
- in_wr_en_mask  in  1  push in_din_mask into the mask FIFO.
- in_din_mask  in  24  mask pixel, same byte layout.
- in_full_mask  out  1  mask FIFO full.
- out_rd_en  in  1  pop the output FIFO.
- out_dout  out  24  result pixel; first-word-fall-through, valid whenever out_empty=0.
- out_empty  out  1  output FIFO empty.

Behaviour:
- Reset (reset=0, async):
  - All FIFOs empty: in_full_*=0, out_empty=1, out_dout=0.
  - Combine stage invalid; pixel counter 0.
- Input FIFOs: independent.
  - Write when full is ignored (no overwrite, no error flag).
  - full asserts the cycle after the FIFO_DEPTH-th unread entry is written.
  - Simultaneous internal pop + external push at full is accepted.
- Output FIFO: FWFT.
  - out_dout shows the head entry while out_empty=0.
  - out_rd_en with out_empty=1 is ignored.
  - Simultaneous push + pop at empty or full is handled without loss.
- Combine stage fires when ped FIFO non-empty AND mask FIFO non-empty AND the output stage can accept.
  - Pops both heads in the same cycle; never pops only one.
  - One registered stage, then push to the output FIFO.
  - Latency from both heads available to out_empty=0: 2 cycles, with the output FIFO empty and not stalled.
- Function, per pixel:
  - mask_hit = (mask != 24'h0).
  - mask_hit=1: out = ped.
  - mask_hit=0: out = {B>>1, G>>1, R>>1} (logical shift per 8-bit channel, no cross-channel carry).
- Backpressure:
  - Output FIFO full stalls the combine stage; no pixel is dropped or duplicated.
  - The registered stage holds its value until pushed.
- Throughput: 1 pixel/cycle sustained when inputs are fed and the output is drained every cycle.
- Pixel counter:
  - Counts completed output pushes, 0..WIDTH*HEIGHT-1.
  - Wraps to 0 after the last pixel of a frame; frames are back-to-back.
  - Internal only; used for the optional feature.
- Reset mid-frame: all in-flight and stored pixels are discarded; the counter returns to 0.

Optional Feature:
- Macro HIGHLIGHT_BORDER_EN.
- Defined: pixels in row 0, row HEIGHT-1, column 0 or column WIDTH-1 (from the pixel counter) are output as 24'h0000FF (pure red) regardless of mask. Interior pixels follow the normal function.
- Undefined: no border logic; all pixels follow the normal function.

Test Plan:
- Reset: hold reset=0 with writes active -> in_full_*=0, out_empty=1; no output appears after release until inputs are written.
- Pass-through: ped=24'h123456, mask=24'hFFFFFF -> out_dout=24'h123456 two cycles after both writes.
- Dim: ped=24'hFF8001, mask=24'h000000 -> out_dout=24'h7F4000.
- Imbalance: write 3 ped pixels only -> out_empty stays 1; then write 3 masks -> exactly 3 outputs, in order.
- Backpressure: out_rd_en=0, stream pixels until in_full_ped=in_full_mask=1; then drain -> all 2*FIFO_DEPTH+1 stored pixels emerge in order, none lost; further writes while full are ignored.
- Full frame: WIDTH*HEIGHT pairs, random out_rd_en -> output count equals WIDTH*HEIGHT and each pixel matches the reference function. With HIGHLIGHT_BORDER_EN, pixel 0 and pixel WIDTH*HEIGHT-1 are 24'h0000FF.
